// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execution-unit state encoding.
// The code values are common to the ALU controller and the execution unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } alu_state_e;

    typedef enum logic [1:0] {
        K_COMB    = 2'd0,
        K_SHIFT   = 2'd1,
        K_MUL     = 2'd2,
        K_ILLEGAL = 2'd3
    } op_kind_e;

    // Classifies an operation code by the execution path that handles it.
    function automatic op_kind_e op_kind(input logic [3:0] code);
        op_kind_e kind;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: kind = K_COMB;
            ALU_SLL, ALU_SRL, ALU_SRA:                  kind = K_SHIFT;
            ALU_MUL:                                    kind = K_MUL;
            default:                                    kind = K_ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU paths: AND, OR, ADD, SUB and signed SLT, with signed
// overflow reported for ADD/SUB only.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic              lt_s;

    assign sum_s  = src_a + src_b;
    assign diff_s = src_a - src_b;
    assign lt_s   = $signed(src_a) < $signed(src_b);

    // Operation select; overflow compares operand and result sign bits.
    always_comb begin
        result   = {DATA_W{1'b0}};
        overflow = 1'b0;
        case (op)
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_ADD: begin
                result   = sum_s;
                overflow = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                           (sum_s[DATA_W-1] != src_a[DATA_W-1]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                           (diff_s[DATA_W-1] != src_a[DATA_W-1]);
            end
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt_s};
            default: result = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith ops, bit-serial shifts and a
// shift-add multiplier behind a start/busy/valid handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_CYC = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    localparam int CNT_W = $clog2(MUL_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_MUL   = CNT_W'(MUL_CYC);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    alu_state_e        state_r, state_nxt_s;
    op_kind_e          kind_s;
    logic [3:0]        op_r;
    logic [DATA_W-1:0] work_a_r, work_b_r, acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] comb_result_s, shift_step_s, mul_acc_s, fin_result_s;
    logic              comb_ovf_s, fin_ovf_s, fin_ill_s, fin_en_s;
    logic [DATA_W-1:0] result_r;
    logic              busy_r, valid_r, zero_r, overflow_r, illegal_r;

    assign kind_s = op_kind(ALUCtrl_i);

    alu_comb_unit #(.DATA_W(DATA_W)) u_comb (
        .op       (ALUCtrl_i),
        .src_a    (src1_i),
        .src_b    (src2_i),
        .result   (comb_result_s),
        .overflow (comb_ovf_s)
    );

    // One-bit shift of the working value (operand B, MIPS rt).
    always_comb begin
        case (op_r)
            ALU_SLL: shift_step_s = {work_a_r[DATA_W-2:0], 1'b0};
            ALU_SRL: shift_step_s = {1'b0, work_a_r[DATA_W-1:1]};
            ALU_SRA: shift_step_s = {work_a_r[DATA_W-1], work_a_r[DATA_W-1:1]};
            default: shift_step_s = work_a_r;
        endcase
    end

    assign mul_acc_s = acc_r + (work_b_r[0] ? work_a_r : DATA_ZERO);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero shift amount behaves like a single-cycle op.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    case (kind_s)
                        K_SHIFT: state_nxt_s = (shamt_i == 5'd0) ? S_DONE : S_SHIFT;
                        K_MUL:   state_nxt_s = S_MUL;
                        default: state_nxt_s = S_DONE;
                    endcase
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SHIFT, S_MUL: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Final result selection for the edge that enters DONE.
    always_comb begin
        fin_result_s = DATA_ZERO;
        fin_ovf_s    = 1'b0;
        fin_ill_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                case (kind_s)
                    K_COMB: begin
                        fin_result_s = comb_result_s;
                        fin_ovf_s    = comb_ovf_s;
                    end
                    K_SHIFT: fin_result_s = src2_i;
                    K_MUL:   fin_result_s = DATA_ZERO;
                    default: fin_ill_s    = 1'b1;
                endcase
            end
            S_SHIFT: fin_result_s = shift_step_s;
            S_MUL:   fin_result_s = mul_acc_s;
            default: fin_result_s = DATA_ZERO;
        endcase
    end

    assign fin_en_s = (state_nxt_s == S_DONE);

    // Operand latch, shift and multiply working registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_r     <= 4'b0000;
            work_a_r <= DATA_ZERO;
            work_b_r <= DATA_ZERO;
            acc_r    <= DATA_ZERO;
            cnt_r    <= CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        op_r  <= ALUCtrl_i;
                        acc_r <= DATA_ZERO;
                        case (kind_s)
                            K_SHIFT: begin
                                work_a_r <= src2_i;
                                work_b_r <= DATA_ZERO;
                                cnt_r    <= CNT_W'(shamt_i);
                            end
                            K_MUL: begin
                                work_a_r <= src1_i;
                                work_b_r <= src2_i;
                                cnt_r    <= CNT_MUL;
                            end
                            default: begin
                                work_a_r <= src1_i;
                                work_b_r <= src2_i;
                                cnt_r    <= CNT_ZERO;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    work_a_r <= shift_step_s;
                    cnt_r    <= cnt_r - CNT_ONE;
                end
                S_MUL: begin
                    acc_r    <= mul_acc_s;
                    work_a_r <= {work_a_r[DATA_W-2:0], 1'b0};
                    work_b_r <= {1'b0, work_b_r[DATA_W-1:1]};
                    cnt_r    <= cnt_r - CNT_ONE;
                end
                default: cnt_r <= CNT_ZERO;
            endcase
        end
    end

    // Registered handshake and result outputs; results hold between ops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            result_r   <= DATA_ZERO;
            zero_r     <= 1'b1;
            overflow_r <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            busy_r  <= (state_nxt_s == S_SHIFT) || (state_nxt_s == S_MUL);
            valid_r <= fin_en_s;
            if (fin_en_s) begin
                result_r   <= fin_result_s;
                zero_r     <= (fin_result_s == DATA_ZERO);
                overflow_r <= fin_ovf_s;
                illegal_r  <= fin_ill_s;
            end
        end
    end

    assign busy_o     = busy_r;
    assign valid_o    = valid_r;
    assign result_o   = result_r;
    assign zero_o     = zero_r;
    assign overflow_o = overflow_r;
    assign illegal_o  = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  ALUCtrl_i = 4'b0000;
    logic [31:0] src1_i = 32'd0;
    logic [31:0] src2_i = 32'd0;
    logic [4:0]  shamt_i = 5'd0;
    logic        busy_o, valid_o, zero_o, overflow_o, illegal_o;
    logic [31:0] result_o;

    int n_pass = 0;
    int n_total = 0;

    alu_exec_unit #(.DATA_W(32), .MUL_CYC(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .ALUCtrl_i  (ALUCtrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .shamt_i    (shamt_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] res, output logic ovf,
                         output logic ill, output int lat);
        longint wide;
        res = 32'd0; ovf = 1'b0; ill = 1'b0; lat = 0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin
                wide = longint'($signed(a)) + longint'($signed(b));
                res  = a + b;
                ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0110: begin
                wide = longint'($signed(a)) - longint'($signed(b));
                res  = a - b;
                ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin res = b << sh; lat = int'(sh); end
            4'b1001: begin res = b >> sh; lat = int'(sh); end
            4'b1010: begin res = $signed(b) >>> sh; lat = int'(sh); end
            4'b1100: begin res = a * b; lat = 32; end
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one op, disturb inputs while busy, then check timing and results.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] e_res;
        logic        e_ovf, e_ill;
        int          e_lat, busy_cnt, guard;
        model(op, a, b, sh, e_res, e_ovf, e_ill, e_lat);
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = op; src1_i = a; src2_i = b; shamt_i = sh;
        @(negedge clk_i);
        start_i = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (!valid_o && guard < 100) begin
            if (busy_o) busy_cnt++;
            start_i = 1'($urandom_range(0, 1));
            ALUCtrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom;
            shamt_i = 5'($urandom);
            @(negedge clk_i);
            guard++;
        end
        chk({tag, "_valid_seen"}, 32'(valid_o), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e_lat));
        chk({tag, "_busy_at_valid"}, 32'(busy_o), 32'd0);
        chk({tag, "_result"}, result_o, e_res);
        chk({tag, "_zero"}, 32'(zero_o), 32'(e_res == 32'd0));
        chk({tag, "_overflow"}, 32'(overflow_o), 32'(e_ovf));
        chk({tag, "_illegal"}, 32'(illegal_o), 32'(e_ill));
        // A start presented during DONE must be ignored.
        start_i = 1'b1; ALUCtrl_i = 4'b0000; src1_i = $urandom; src2_i = $urandom;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_valid_pulse"}, 32'(valid_o), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_held"}, result_o, e_res);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_result"}, result_o, 32'd0);
        chk({tag, "_zero"}, 32'(zero_o), 32'd1);
        chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_o), 32'd0);
    endtask

    initial begin
        logic [3:0] codes [10];
        int vseen;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                  4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b0011};

        repeat (2) @(negedge clk_i);
        chk_reset_vals("reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0);
        run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        run_op("slt_pos", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0);
        run_op("and", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
        run_op("or", 4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
        run_op("sra4", 4'b1010, 32'h0, 32'h8000_0000, 5'd4);
        run_op("sll0", 4'b1000, 32'h0, 32'h1234_5678, 5'd0);
        run_op("srl31", 4'b1001, 32'h0, 32'h8000_0000, 5'd31);
        run_op("mul", 4'b1100, 32'h0001_0003, 32'h0000_0005, 5'd0);
        run_op("mul_trunc", 4'b1100, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0);

        run_op("illegal", 4'b0011, 32'h1111_1111, 32'h2222_2222, 5'd0);
        repeat (3) @(negedge clk_i);
        chk("illegal_hold", 32'(illegal_o), 32'd1);
        run_op("after_illegal", 4'b0010, 32'd7, 32'd8, 5'd0);

        // Reset in the middle of a multiply aborts it without a valid pulse.
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = 4'b1100; src1_i = 32'd9; src2_i = 32'd9;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk_reset_vals("abort");
        vseen = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (valid_o) vseen++;
        end
        rst_i = 1'b1;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) vseen++;
        end
        chk("abort_no_valid", 32'(vseen), 32'd0);
        run_op("post_reset_add", 4'b0010, 32'd2, 32'd3, 5'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
            rb = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            run_op($sformatf("rand%0d", i), codes[$urandom_range(0, 9)], ra, rb,
                   5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
